// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU (AND/OR/XOR/ADD/SUB/SLT/SRL/MUL); ALU_SEQ_MUL_EN builds the iterative multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MUL. Result is held in DONE until out_ready; no new op is accepted until then.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state, stateNext;

  logic             accept;
  logic [WIDTH:0]   sumW, diffW;
  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluV;

  assign accept = in_valid && in_ready;
  assign sumW   = {1'b0, in_a} + {1'b0, in_b};
  assign diffW  = {1'b0, in_a} - {1'b0, in_b};

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiplier: one multiplier bit consumed per BUSY cycle.
  logic [2*WIDTH-1:0] acc, mcand, accNext;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               lastIter;

  assign accNext  = acc + (mplier[0] ? mcand : '0);
  assign lastIter = (cnt == SHW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (in_valid) stateNext = (op == OP_MUL) ? BUSY : DONE;
`else
        if (in_valid) stateNext = DONE;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: if (lastIter) stateNext = DONE;
`endif
      DONE: if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Op 111 falls to the default arm: zero result unless the multiplier takes it.
  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (op)
      OP_AND: aluRes = in_a & in_b;
      OP_OR:  aluRes = in_a | in_b;
      OP_XOR: aluRes = in_a ^ in_b;
      OP_ADD: begin
        aluRes = sumW[WIDTH-1:0];
        aluC   = sumW[WIDTH];
        aluV   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sumW[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diffW[WIDTH-1:0];
        aluC   = diffW[WIDTH];
        aluV   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diffW[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLT: aluRes = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SRL: aluRes = in_a >> in_b[SHW-1:0];
      default: aluRes = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (op == OP_MUL) begin
        acc    <= '0;
        cnt    <= '0;
        mcand  <= {{WIDTH{1'b0}}, in_a};
        mplier <= in_b;
      end else begin
`endif
        result <= aluRes;
        flag_z <= (aluRes == '0);
        flag_c <= aluC;
        flag_v <= aluV;
`ifdef ALU_SEQ_MUL_EN
      end
`endif
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state == BUSY) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (lastIter) begin
        result <= accNext[WIDTH-1:0];
        flag_z <= (accNext[WIDTH-1:0] == '0);
        flag_c <= |accNext[2*WIDTH-1:WIDTH];
        flag_v <= 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, reset/backpressure sequences, and random ops vs. an arithmetic model.
module tb_alu_seq;
  localparam int W   = 8;
  localparam int SHW = $clog2(W);
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_v;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic [2:0]   o;
    logic [W-1:0] res;
    logic         z, c, v;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions, using wide integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, t, s, modv, maxS, minS;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    modv = longint'(1) << W;
    maxS = (longint'(1) << (W - 1)) - 1;
    minS = -(longint'(1) << (W - 1));
    c = 1'b0;
    v = 1'b0;
    t = 0;
    case (o)
      3'd0: t = ua & ub;
      3'd1: t = ua | ub;
      3'd2: t = ua ^ ub;
      3'd3: begin
        t = ua + ub;
        c = (t >= modv);
        s = sa + sb;
        v = (s > maxS) || (s < minS);
      end
      3'd4: begin
        t = ua - ub;
        c = (ua < ub);
        s = sa - sb;
        v = (s > maxS) || (s < minS);
      end
      3'd5: t = (sa < sb) ? 1 : 0;
      3'd6: t = ua >> (ub % (longint'(1) << SHW));
      default: begin
`ifdef ALU_SEQ_MUL_EN
        t = ua * ub;
        c = (t >= modv);
`else
        t = 0;
`endif
      end
    endcase
    r = t[W-1:0];
  endfunction

  // Presents one op at a negedge, keeps in_valid high with junk after acceptance, then consumes the result.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                       output logic [W-1:0] r, output logic z, output logic c, output logic v,
                       output int lat, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_a = a; in_b = b; op = o; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = W'($urandom); in_b = W'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid;
    r = result; z = flag_z; c = flag_c; v = flag_v;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic doVec(input string tag, input vec_t t);
    logic [W-1:0] r;
    logic z, c, v;
    int lat;
    bit ok;
    runOp(t.a, t.b, t.o, r, z, c, v, lat, ok);
    check({tag, " out_valid seen"}, longint'(ok), 1);
    check({tag, " latency"}, lat, t.lat);
    check({tag, " result"}, r, t.res);
    check({tag, " flag_z"}, z, t.z);
    check({tag, " flag_c"}, c, t.c);
    check({tag, " flag_v"}, v, t.v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    logic [W-1:0] mr;
    logic mc, mv;
    bit seenValid;

    vecs.push_back('{8'h7F, 8'h01, 3'd3, 8'h80, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{8'hFF, 8'h01, 3'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{8'h02, 8'h05, 3'd4, 8'hFD, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{8'h80, 8'h01, 3'd4, 8'h7F, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{8'h80, 8'h01, 3'd5, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{8'h01, 8'h80, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{8'hF0, 8'h0B, 3'd6, 8'h1E, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{8'hC3, 8'h0F, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{8'hC3, 8'h0F, 3'd1, 8'hCF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{8'hC3, 8'h0F, 3'd2, 8'hCC, 1'b0, 1'b0, 1'b0, 1});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{8'h12, 8'h34, 3'd7, 8'hA8, 1'b0, 1'b1, 1'b0, MUL_LAT});
`else
    vecs.push_back('{8'h12, 8'h34, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0, MUL_LAT});
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", {flag_z, flag_c, flag_v}, 0);

    foreach (vecs[i]) doVec($sformatf("vec%0d", i), vecs[i]);

    // Reset four cycles into a multiply: nothing from it may surface afterwards.
    in_a = 8'h03; in_b = 8'h05; op = 3'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midmul reset in_ready", in_ready, 1);
    check("midmul reset out_valid", out_valid, 0);
    check("midmul reset result", result, 0);
    check("midmul reset flags", {flag_z, flag_c, flag_v}, 0);
    seenValid = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (out_valid) seenValid = 1'b1;
    end
    check("midmul no stale out_valid", seenValid, 0);

    // Backpressure: held DONE with a new op waiting on the input side.
    in_a = 8'h7F; in_b = 8'h01; op = 3'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 8'hC3; in_b = 8'h0F; op = 3'd2;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
      check($sformatf("bp%0d result", k), result, 8'h80);
      check($sformatf("bp%0d flags", k), {flag_z, flag_c, flag_v}, 3'b001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next out_valid", out_valid, 1);
    check("bp next result", result, 8'hCC);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      t.a = W'($urandom);
      t.b = W'($urandom);
      t.o = 3'($urandom_range(0, 7));
      if (i % 8 == 0) t.b = '0;
      model(t.a, t.b, t.o, mr, mc, mv);
      t.res = mr;
      t.z = (mr == '0);
      t.c = mc;
      t.v = mv;
      t.lat = (t.o == 3'd7) ? MUL_LAT : 1;
      doVec($sformatf("rnd%0d op%0d", i, t.o), t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
